// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, byte-addressable instruction/data memory between
// instruction fetch (IF) and the load/store unit (DM). Each cycle at most one
// requester is granted with a combinational req/gnt handshake. DM has fixed
// priority, bounded by a streak counter so a waiting fetch is never starved
// for more than MAX_DATA_STREAK consecutive data grants. The memory has a
// 1-cycle synchronous read, so read data is steered back to the requester
// recorded in the owner register one cycle after its grant.
//
// Parameters
//   ADDR_W           byte-address width driven to memory
//   MAX_DATA_STREAK  consecutive DM grants allowed while IF waits (1..15)
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   if_req/if_addr              fetch request; if_addr[1:0] forced to 0
//   if_gnt/if_rvalid/if_rdata   fetch grant and response
//   halt                        blocks new IF grants
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_funct3          data request (load/store, size/sign)
//   dm_gnt/dm_rvalid/dm_rdata/
//   dm_err                      data grant, response, misalignment error
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_funct3        memory strobe, write enable and payload
//   mem_rdata                   memory read data (1 cycle after read)
//
// Optional build macro ARB_PERF_CNT_EN adds if_wait_cnt / dm_wait_cnt, which
// count cycles each requester spent waiting. Arbitration is unaffected.
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_W          = 9,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              halt,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       dm_wait_cnt,
`endif
    input  logic [31:0]       mem_rdata
);

    // What the cycle after a grant must report. Error responses are tracked
    // here as well because a misaligned access never reaches the memory.
    typedef enum logic [2:0] {
        RSP_NONE,
        RSP_IF,
        RSP_DM,
        RSP_ERR_LD,
        RSP_ERR_ST
    } rsp_e;

    localparam logic [3:0]        STREAK_MAX  = 4'(MAX_DATA_STREAK);
    localparam logic [2:0]        FUNCT3_LW   = 3'b010;
    localparam logic [ADDR_W-1:0] WORD_MASK   = {{(ADDR_W-2){1'b1}}, 2'b00};

    rsp_e       rsp_q, rsp_d;
    logic [3:0] streak_q, streak_d;
    logic       dm_win, if_win, dm_mis;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        dm_win     = 1'b0;
        if_win     = 1'b0;
        dm_mis     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        rsp_d      = RSP_NONE;
        streak_d   = streak_q;

        // funct3[1:0] encodes the size: 00 byte, 01 half, 10 word.
        dm_mis = ((dm_funct3[1:0] == 2'b10) && (dm_addr[1:0] != 2'b00)) ||
                 ((dm_funct3[1:0] == 2'b01) && dm_addr[0]);

        // Grants are suppressed while reset is held so every output reads 0.
        dm_win = reset && dm_req &&
                 ((streak_q < STREAK_MAX) || !if_req || halt);
        if_win = reset && !dm_win && if_req && !halt;

        if (dm_win) begin
            mem_addr   = dm_addr;
            mem_wdata  = dm_wdata;
            mem_funct3 = dm_funct3;
            // A misaligned access is still granted, but the macro is not
            // touched; the error is reported on the following cycle.
            mem_en     = !dm_mis;
            mem_we     = dm_we && !dm_mis;
            if (dm_mis)
                rsp_d = dm_we ? RSP_ERR_ST : RSP_ERR_LD;
            else
                rsp_d = dm_we ? RSP_NONE : RSP_DM;
        end else if (if_win) begin
            mem_addr   = if_addr & WORD_MASK;
            mem_funct3 = FUNCT3_LW;
            mem_en     = 1'b1;
            rsp_d      = RSP_IF;
        end

        // The streak only matters while a fetch is actually waiting.
        if (!if_req || halt || if_win)
            streak_d = '0;
        else if (dm_win && (streak_q < STREAK_MAX))
            streak_d = streak_q + 4'd1;
    end

    assign if_gnt = if_win;
    assign dm_gnt = dm_win;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_q    <= RSP_NONE;
            streak_q <= '0;
        end else begin
            rsp_q    <= rsp_d;
            streak_q <= streak_d;
        end
    end

    assign if_rvalid = (rsp_q == RSP_IF);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign dm_rvalid = (rsp_q == RSP_DM) || (rsp_q == RSP_ERR_LD);
    assign dm_rdata  = (rsp_q == RSP_DM) ? mem_rdata : 32'd0;
    assign dm_err    = (rsp_q == RSP_ERR_LD) || (rsp_q == RSP_ERR_ST);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_wait_cnt_q, if_wait_cnt_d;
    logic [31:0] dm_wait_cnt_q, dm_wait_cnt_d;

    always_comb begin
        if_wait_cnt_d = if_wait_cnt_q;
        dm_wait_cnt_d = dm_wait_cnt_q;
        if (if_req && !halt && !if_win)
            if_wait_cnt_d = if_wait_cnt_q + 32'd1;
        if (dm_req && !dm_win)
            dm_wait_cnt_d = dm_wait_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_wait_cnt_q <= '0;
            dm_wait_cnt_q <= '0;
        end else begin
            if_wait_cnt_q <= if_wait_cnt_d;
            dm_wait_cnt_q <= dm_wait_cnt_d;
        end
    end

    assign if_wait_cnt = if_wait_cnt_q;
    assign dm_wait_cnt = dm_wait_cnt_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Bench for unified_mem_arbiter. A table of per-cycle input vectors carries
// the expected grant/memory-strobe outputs and the expected response for the
// following cycle; responses are queued when a vector is driven and popped
// when the response cycle arrives. A small behavioural memory answers reads
// one cycle late. A hand-written sequence covers reset during an outstanding
// fetch.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int ADDR_W = 9;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;

    typedef enum logic [2:0] {R_NONE, R_IF, R_DM, R_ERR_LD, R_ERR_ST} rsp_e;

    typedef struct {
        logic              if_req;
        logic              halt;
        logic              dm_req;
        logic              dm_we;
        logic [ADDR_W-1:0] if_addr;
        logic [ADDR_W-1:0] dm_addr;
        logic [2:0]        f3;
        logic [31:0]       wdata;
        logic              e_if_gnt;
        logic              e_dm_gnt;
        logic              e_mem_en;
        logic              e_mem_we;
        logic [ADDR_W-1:0] e_addr;
        rsp_e              e_rsp;
        logic [31:0]       e_data;
    } vec_t;

    typedef struct {
        rsp_e        kind;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, halt, dm_req, dm_we;
    logic [ADDR_W-1:0] if_addr, dm_addr;
    logic [31:0]       dm_wdata;
    logic [2:0]        dm_funct3;
    logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err;
    logic [31:0]       if_rdata, dm_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [2:0]        mem_funct3;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       if_wait_cnt, dm_wait_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .halt       (halt),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_funct3  (dm_funct3),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .dm_err     (dm_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
`ifdef ARB_PERF_CNT_EN
        .if_wait_cnt(if_wait_cnt),
        .dm_wait_cnt(dm_wait_cnt),
`endif
        .mem_rdata  (mem_rdata)
    );

    // Behavioural memory: unwritten words hold a recognisable pattern.
    logic [31:0] mem_arr [128];
    bit          written [128];

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4)
            return 32'h0050_0093;
        return {16'hC0DE, 16'(idx)};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[int'(mem_addr[8:2])] <= mem_wdata;
                written[int'(mem_addr[8:2])] <= 1'b1;
            end else begin
                mem_rdata <= written[int'(mem_addr[8:2])] ?
                             mem_arr[int'(mem_addr[8:2])] :
                             init_word(int'(mem_addr[8:2]));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_resp(input int tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty_%0d: no expected response queued", tag);
            return;
        end
        e = sb.pop_front();
        check($sformatf("r%0d_if_rvalid", tag), 32'(if_rvalid),
              32'(e.kind == R_IF));
        check($sformatf("r%0d_if_rdata", tag), if_rdata,
              (e.kind == R_IF) ? e.data : 32'd0);
        check($sformatf("r%0d_dm_rvalid", tag), 32'(dm_rvalid),
              32'((e.kind == R_DM) || (e.kind == R_ERR_LD)));
        check($sformatf("r%0d_dm_rdata", tag), dm_rdata,
              (e.kind == R_DM) ? e.data : 32'd0);
        check($sformatf("r%0d_dm_err", tag), 32'(dm_err),
              32'((e.kind == R_ERR_LD) || (e.kind == R_ERR_ST)));
    endtask

    function automatic vec_t mk(
        input logic ir, input logic h, input logic dr, input logic we,
        input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
        input logic [2:0] f3, input logic [31:0] wd,
        input logic eig, input logic edg, input logic een, input logic ewe,
        input logic [ADDR_W-1:0] ea, input rsp_e er, input logic [31:0] ed);
        vec_t v;
        v.if_req = ir;   v.halt = h;     v.dm_req = dr;   v.dm_we = we;
        v.if_addr = ia;  v.dm_addr = da; v.f3 = f3;       v.wdata = wd;
        v.e_if_gnt = eig; v.e_dm_gnt = edg; v.e_mem_en = een;
        v.e_mem_we = ewe; v.e_addr = ea; v.e_rsp = er;    v.e_data = ed;
        return v;
    endfunction

    task automatic drive_idle();
        if_req = 1'b0; halt = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0;  dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_if_gnt"},     32'(if_gnt),     32'd0);
        check({pfx, "_dm_gnt"},     32'(dm_gnt),     32'd0);
        check({pfx, "_if_rvalid"},  32'(if_rvalid),  32'd0);
        check({pfx, "_if_rdata"},   if_rdata,        32'd0);
        check({pfx, "_dm_rvalid"},  32'(dm_rvalid),  32'd0);
        check({pfx, "_dm_rdata"},   dm_rdata,        32'd0);
        check({pfx, "_dm_err"},     32'(dm_err),     32'd0);
        check({pfx, "_mem_en"},     32'(mem_en),     32'd0);
        check({pfx, "_mem_we"},     32'(mem_we),     32'd0);
        check({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({pfx, "_mem_wdata"},  mem_wdata,       32'd0);
        check({pfx, "_mem_funct3"}, 32'(mem_funct3), 32'd0);
    endtask

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        vec_t v;
        // if_req h  dm  we  if_addr dm_addr f3  wdata | if dm en we addr rsp data
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,9'h010,9'h000,F_LW,32'h0,
                      1'b1,1'b0,1'b1,1'b0,9'h010,R_IF,32'h0050_0093);
        vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,9'h013,9'h000,F_LW,32'h0,
                      1'b1,1'b0,1'b1,1'b0,9'h010,R_IF,32'h0050_0093);
        vecs[2]  = mk(1'b1,1'b0,1'b1,1'b0,9'h014,9'h020,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h020,R_DM,32'hC0DE_0008);
        vecs[3]  = mk(1'b1,1'b0,1'b1,1'b0,9'h014,9'h024,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h024,R_DM,32'hC0DE_0009);
        vecs[4]  = mk(1'b1,1'b0,1'b1,1'b0,9'h014,9'h028,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h028,R_DM,32'hC0DE_000A);
        vecs[5]  = mk(1'b1,1'b0,1'b1,1'b0,9'h014,9'h02C,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h02C,R_DM,32'hC0DE_000B);
        // Streak of 4 reached: the waiting fetch wins, then DM resumes.
        vecs[6]  = mk(1'b1,1'b0,1'b1,1'b0,9'h014,9'h030,F_LW,32'h0,
                      1'b1,1'b0,1'b1,1'b0,9'h014,R_IF,32'hC0DE_0005);
        vecs[7]  = mk(1'b1,1'b0,1'b1,1'b0,9'h018,9'h030,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h030,R_DM,32'hC0DE_000C);
        // Store then load back.
        vecs[8]  = mk(1'b0,1'b0,1'b1,1'b1,9'h000,9'h104,F_LW,32'hDEAD_BEEF,
                      1'b0,1'b1,1'b1,1'b1,9'h104,R_NONE,32'h0);
        vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,9'h000,9'h104,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h104,R_DM,32'hDEAD_BEEF);
        // Misaligned LW and SH.
        vecs[10] = mk(1'b0,1'b0,1'b1,1'b0,9'h000,9'h102,F_LW,32'h0,
                      1'b0,1'b1,1'b0,1'b0,9'h000,R_ERR_LD,32'h0);
        vecs[11] = mk(1'b0,1'b0,1'b1,1'b1,9'h000,9'h101,F_LH,32'h1234,
                      1'b0,1'b1,1'b0,1'b0,9'h000,R_ERR_ST,32'h0);
        // Halt blocks fetches but data is still served.
        vecs[12] = mk(1'b1,1'b1,1'b0,1'b0,9'h018,9'h000,F_LW,32'h0,
                      1'b0,1'b0,1'b0,1'b0,9'h000,R_NONE,32'h0);
        vecs[13] = mk(1'b1,1'b1,1'b1,1'b0,9'h018,9'h030,F_LW,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h030,R_DM,32'hC0DE_000C);
        vecs[14] = mk(1'b1,1'b1,1'b1,1'b0,9'h018,9'h102,F_LH,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h102,R_DM,32'hC0DE_0040);
        vecs[15] = mk(1'b1,1'b0,1'b1,1'b0,9'h018,9'h103,F_LBU,32'h0,
                      1'b0,1'b1,1'b1,1'b0,9'h103,R_DM,32'hC0DE_0040);
        // Fetch granted, then halt rises: that fetch still returns.
        vecs[16] = mk(1'b1,1'b0,1'b0,1'b0,9'h018,9'h000,F_LB,32'h0,
                      1'b1,1'b0,1'b1,1'b0,9'h018,R_IF,32'hC0DE_0006);
        vecs[17] = mk(1'b1,1'b1,1'b0,1'b0,9'h018,9'h000,F_LB,32'h0,
                      1'b0,1'b0,1'b0,1'b0,9'h000,R_NONE,32'h0);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,F_LB,32'h0,
                      1'b0,1'b0,1'b0,1'b0,9'h000,R_NONE,32'h0);

        // Reset state, with requests pending so the gating is exercised.
        reset = 1'b0;
        drive_idle();
        if_req = 1'b1; if_addr = 9'h010;
        dm_req = 1'b1; dm_addr = 9'h020; dm_funct3 = F_LW;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        sb.push_back('{R_NONE, 32'h0});

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            check_resp(i);
            v = vecs[i];
            if_req = v.if_req;   halt = v.halt;       dm_req = v.dm_req;
            dm_we = v.dm_we;     if_addr = v.if_addr; dm_addr = v.dm_addr;
            dm_funct3 = v.f3;    dm_wdata = v.wdata;
            #1;
            check($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(v.e_if_gnt));
            check($sformatf("v%0d_dm_gnt", i), 32'(dm_gnt), 32'(v.e_dm_gnt));
            check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(v.e_mem_en));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.e_mem_we));
            if (v.e_mem_en) begin
                check($sformatf("v%0d_mem_addr", i), 32'(mem_addr),
                      32'(v.e_addr));
                check($sformatf("v%0d_mem_funct3", i), 32'(mem_funct3),
                      32'(v.e_if_gnt ? F_LW : v.f3));
            end
            if (v.e_mem_we)
                check($sformatf("v%0d_mem_wdata", i), mem_wdata, v.wdata);
            sb.push_back('{v.e_rsp, v.e_data});
        end
        @(posedge clk);
        #1;
        check_resp(NV);

        // Reset asserted in the cycle after a fetch grant drops the fetch.
        drive_idle();
        if_req = 1'b1; if_addr = 9'h010;
        #1;
        check("rst_seq_if_gnt", 32'(if_gnt), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dm_req = 1'b1; dm_addr = 9'h020; dm_funct3 = F_LW;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_post%0d_if_rvalid", c), 32'(if_rvalid), 32'd0);
            check($sformatf("rst_post%0d_dm_rvalid", c), 32'(dm_rvalid), 32'd0);
        end

        // Normal fetch after the release.
        if_req = 1'b1; if_addr = 9'h01C;
        #1;
        check("post_rst_if_gnt", 32'(if_gnt), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        check("post_rst_if_rvalid", 32'(if_rvalid), 32'd1);
        check("post_rst_if_rdata", if_rdata, 32'hC0DE_0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
